vin_src_ctrl: RTL

- Source-select controller for the board video input stage. Runs on the system clock.
- Monitors frame timing of the FPD-Link and DPI receivers and qualifies each source as locked.
- Arbitrates between them with FPD-Link priority and sequences every switch as mute -> select -> flush -> resync, so the clock mux and per-frame FIFO never see a mid-frame change.

---
 rtl/vin_pkg.sv | 29 ++
 rtl/vin_src_mon.sv | 82 ++++++++
 rtl/vin_src_ctrl.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/vin_pkg.sv
// rtl/vin_pkg.sv - shared state encoding, select constants and arbitration helper for the video input source controller
package vin_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_MUTE    = 3'd1,
        ST_SWITCH  = 3'd2,
        ST_WAIT_VS = 3'd3,
        ST_RUN     = 3'd4
    } vin_state_e;

    localparam logic SEL_DPI = 1'b0;
    localparam logic SEL_FPD = 1'b1;

    // valid = 0 means no source is eligible; sel is then meaningless.
    typedef struct packed {
        logic valid;
        logic sel;
    } vin_target_t;

    // Fixed-priority choice: FPD-Link beats DPI whenever both are locked.
    function automatic vin_target_t prio_target(input logic fpd_lk, input logic dpi_lk);
        vin_target_t t;
        t.valid = fpd_lk | dpi_lk;
        t.sel   = fpd_lk ? SEL_FPD : SEL_DPI;
        return t;
    endfunction

endpackage

// File: rtl/vin_src_mon.sv
// rtl/vin_src_mon.sv - per-source vsync period monitor and lock qualifier
//
// Ports:
//   clk      in   system clock
//   rst      in   asynchronous reset, active-high
//   vsync    in   vsync already synchronised to clk
//   locked   out  registered: LOCK_FRAMES consecutive consistent periods seen
//   vs_edge  out  combinational rising-edge strobe of vsync (1 clk detection latency)
module vin_src_mon #(
    parameter int CNT_W       = 24,
    parameter int LOCK_FRAMES = 4,
    parameter int PERIOD_TOL  = 64,
    parameter int TIMEOUT_CYC = 2000000
) (
    input  logic clk,
    input  logic rst,
    input  logic vsync,
    output logic locked,
    output logic vs_edge
);

    localparam int SC_W = $clog2(LOCK_FRAMES + 1);
    localparam logic [CNT_W-1:0] TOL      = CNT_W'(PERIOD_TOL);
    localparam logic [CNT_W-1:0] TIMEOUT  = CNT_W'(TIMEOUT_CYC);
    localparam logic [SC_W-1:0]  LOCK_CNT = SC_W'(LOCK_FRAMES);

    logic             vs_d;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] prev;
    logic             prev_valid;
    logic [SC_W-1:0]  stable_cnt;
    logic [SC_W-1:0]  stable_nxt;
    logic [CNT_W-1:0] diff;
    logic             consistent;
    logic             timeout;

    assign vs_edge = vsync & ~vs_d;
    assign timeout = (cnt == TIMEOUT);

    // cnt holds the length of the period that ends on this edge.
    always_comb begin
        diff       = (cnt >= prev) ? (cnt - prev) : (prev - cnt);
        consistent = prev_valid && (diff <= TOL);
        stable_nxt = stable_cnt;
        if (vs_edge) begin
            if (consistent) begin
                stable_nxt = (stable_cnt == LOCK_CNT) ? stable_cnt : stable_cnt + 1'b1;
            end else begin
                stable_nxt = '0;
            end
        end else if (timeout) begin
            stable_nxt = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vs_d       <= 1'b0;
            cnt        <= '0;
            prev       <= '0;
            prev_valid <= 1'b0;
            stable_cnt <= '0;
            locked     <= 1'b0;
        end else begin
            vs_d       <= vsync;
            stable_cnt <= stable_nxt;
            // Lock follows the updated count so it moves the cycle after the edge/timeout.
            locked     <= (stable_nxt == LOCK_CNT);
            if (vs_edge) begin
                // An edge coincident with timeout is still a valid period.
                cnt        <= CNT_W'(1);
                prev       <= cnt;
                prev_valid <= 1'b1;
            end else if (timeout) begin
                prev_valid <= 1'b0;
            end else if (cnt != '1) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/vin_src_ctrl.sv
// rtl/vin_src_ctrl.sv - video input source select controller (optional manual override: VIN_SRC_FORCE_EN)
//
// Ports:
//   clk         in   system clock
//   rst         in   asynchronous reset, active-high
//   fpd_vsync   in   FPD-Link vsync, synchronised to clk
//   dpi_vsync   in   DPI vsync, synchronised to clk
//   force_en    in   (VIN_SRC_FORCE_EN only) override priority arbitration
//   force_sel   in   (VIN_SRC_FORCE_EN only) forced source, 0 = DPI, 1 = FPD-Link
//   vi_select   out  0 = DPI, 1 = FPD-Link; changes only while leaving SWITCH
//   v_mute      out  1 = downstream ignores v_valid and pixels; low only in RUN
//   fifo_flush  out  single-cycle pulse resetting the input FIFO
//   fpd_locked  out  FPD-Link source qualified
//   dpi_locked  out  DPI source qualified
//   state_dbg   out  current FSM state encoding
module vin_src_ctrl
    import vin_pkg::*;
#(
    parameter int CNT_W       = 24,
    parameter int LOCK_FRAMES = 4,
    parameter int PERIOD_TOL  = 64,
    parameter int TIMEOUT_CYC = 2000000,
    parameter int MUTE_CYC    = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       fpd_vsync,
    input  logic       dpi_vsync,
`ifdef VIN_SRC_FORCE_EN
    input  logic       force_en,
    input  logic       force_sel,
`endif
    output logic       vi_select,
    output logic       v_mute,
    output logic       fifo_flush,
    output logic       fpd_locked,
    output logic       dpi_locked,
    output logic [2:0] state_dbg
);

    localparam logic [CNT_W-1:0] MUTE_LAST = CNT_W'(MUTE_CYC - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    vin_state_e       state, state_nxt;
    logic             sel_nxt;
    logic [CNT_W-1:0] seq_cnt, cnt_nxt;
    logic             fpd_edge, dpi_edge;
    logic             sel_locked, sel_edge;
    vin_target_t      target;

    vin_src_mon #(
        .CNT_W(CNT_W), .LOCK_FRAMES(LOCK_FRAMES), .PERIOD_TOL(PERIOD_TOL), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_fpd_mon (
        .clk(clk), .rst(rst), .vsync(fpd_vsync), .locked(fpd_locked), .vs_edge(fpd_edge)
    );

    vin_src_mon #(
        .CNT_W(CNT_W), .LOCK_FRAMES(LOCK_FRAMES), .PERIOD_TOL(PERIOD_TOL), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_dpi_mon (
        .clk(clk), .rst(rst), .vsync(dpi_vsync), .locked(dpi_locked), .vs_edge(dpi_edge)
    );

    always_comb begin
        target = '0;
`ifdef VIN_SRC_FORCE_EN
        if (force_en) begin
            // Forced source is used only when it is actually locked.
            target.valid = (force_sel == SEL_FPD) ? fpd_locked : dpi_locked;
            target.sel   = force_sel;
        end else begin
            target = prio_target(fpd_locked, dpi_locked);
        end
`else
        target = prio_target(fpd_locked, dpi_locked);
`endif
    end

    assign sel_locked = (vi_select == SEL_FPD) ? fpd_locked : dpi_locked;
    assign sel_edge   = (vi_select == SEL_FPD) ? fpd_edge   : dpi_edge;
    assign state_dbg  = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            vi_select <= SEL_DPI;
            seq_cnt   <= '0;
        end else begin
            state     <= state_nxt;
            vi_select <= sel_nxt;
            seq_cnt   <= cnt_nxt;
        end
    end

    // seq_cnt times the mute settle window in MUTE and the vsync wait in WAIT_VS.
    always_comb begin
        state_nxt  = state;
        sel_nxt    = vi_select;
        cnt_nxt    = '0;
        v_mute     = 1'b1;
        fifo_flush = 1'b0;
        case (state)
            ST_IDLE: begin
                if (target.valid) state_nxt = ST_MUTE;
            end
            ST_MUTE: begin
                if (!target.valid) begin
                    state_nxt = ST_IDLE;
                end else if (seq_cnt == MUTE_LAST) begin
                    state_nxt = ST_SWITCH;
                end else begin
                    cnt_nxt = seq_cnt + 1'b1;
                end
            end
            ST_SWITCH: begin
                // Target is re-sampled here so late changes during MUTE take effect.
                if (target.valid) begin
                    sel_nxt    = target.sel;
                    fifo_flush = 1'b1;
                    state_nxt  = ST_WAIT_VS;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_WAIT_VS: begin
                if (sel_edge) begin
                    state_nxt = ST_RUN;
                end else if (!sel_locked || seq_cnt == WAIT_LAST) begin
                    state_nxt = ST_IDLE;
                end else begin
                    cnt_nxt = seq_cnt + 1'b1;
                end
            end
            ST_RUN: begin
                v_mute = 1'b0;
                if (!sel_locked) begin
                    state_nxt = target.valid ? ST_MUTE : ST_IDLE;
                end else if (target.sel != vi_select) begin
                    state_nxt = ST_MUTE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule
